// File: rtl/matmul_sched_pkg.sv
// Shared definitions for the matmul engine scheduler: FSM state encoding and
// default configuration values.
package matmul_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam int NUM_REQ_DEF     = 4;
   localparam int CNT_BITS_DEF    = 16;
   localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/matmul_sched_if.sv
// Request/engine/status bundle between the host registers, the matmul engine
// and the scheduler. master = scheduler side, slave = host + engine side.
interface matmul_sched_if
   import matmul_sched_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int SEL_BITS = $clog2(NUM_REQ),
   parameter int CNT_BITS = CNT_BITS_DEF
);

   logic [NUM_REQ-1:0]  req;
   logic                start_mul;
   logic                mul_done;
   logic [SEL_BITS-1:0] sel;
   logic                busy;
   logic [NUM_REQ-1:0]  done;
   logic                err;
   logic [CNT_BITS-1:0] jobs;

   modport master (
      input  req, mul_done,
      output start_mul, sel, busy, done, err, jobs
   );

   modport slave (
      output req, mul_done,
      input  start_mul, sel, busy, done, err, jobs
   );

endinterface

// File: rtl/matmul_sched_rr_pick.sv
// Combinational round-robin selector: grants the first set request bit
// searching rr+1, rr+2, ... modulo NUM_REQ. Reusable by any shared-resource arbiter.
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int SEL_BITS = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [SEL_BITS-1:0] rr_i,
   output logic [SEL_BITS-1:0] grant_o,
   output logic                valid_o
);

   logic [SEL_BITS-1:0] idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      // Scan from the farthest candidate down so the nearest one after rr wins.
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = SEL_BITS'((int'(rr_i) + i) % NUM_REQ);
         if (req_i[idx]) begin
            grant_o = idx;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing one vector matmul engine among NUM_REQ requesters.
// Optional watchdog enabled by defining MATMUL_SCHED_TIMEOUT_EN.
module matmul_sched
   import matmul_sched_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int SEL_BITS    = $clog2(NUM_REQ),
   parameter int CNT_BITS    = CNT_BITS_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   matmul_sched_if.master  bus
);

   if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
      $error("matmul_sched: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
   end

   state_e              state_q;
   logic                start_mul_q;
   logic [SEL_BITS-1:0] sel_q;
   logic [SEL_BITS-1:0] rr_q;
   logic                busy_q;
   logic [NUM_REQ-1:0]  done_q;
   logic [NUM_REQ-1:0]  done_d;
   logic [CNT_BITS-1:0] jobs_q;

   logic [SEL_BITS-1:0] pick_grant;
   logic                pick_valid;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .SEL_BITS (SEL_BITS)
   ) u_rr_pick (
      .req_i   (bus.req),
      .rr_i    (rr_q),
      .grant_o (pick_grant),
      .valid_o (pick_valid)
   );

   assign done_d = NUM_REQ'(1) << sel_q;

`ifdef MATMUL_SCHED_TIMEOUT_EN
   localparam int WDOG_BITS = $clog2(TIMEOUT_CYC + 1);

   logic [WDOG_BITS-1:0] wdog_q;
   logic                 err_q;
   logic                 timeout_hit;

   // Fires on the TIMEOUT_CYC-th RUN cycle without a completion.
   assign timeout_hit = (wdog_q == WDOG_BITS'(TIMEOUT_CYC - 1));
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         start_mul_q <= 1'b0;
         sel_q       <= '0;
         rr_q        <= SEL_BITS'(NUM_REQ - 1);
         busy_q      <= 1'b0;
         done_q      <= '0;
         jobs_q      <= '0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
         wdog_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         start_mul_q <= 1'b0;
         done_q      <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  sel_q       <= pick_grant;
                  busy_q      <= 1'b1;
                  start_mul_q <= 1'b1;
                  state_q     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               state_q <= ST_RUN;
`ifdef MATMUL_SCHED_TIMEOUT_EN
               wdog_q  <= '0;
`endif
            end
            ST_RUN: begin
               // Completion is registered here so done/busy/jobs are all visible in FIN.
               if (bus.mul_done) begin
                  done_q  <= done_d;
                  jobs_q  <= jobs_q + 1'b1;
                  busy_q  <= 1'b0;
                  rr_q    <= sel_q;
                  state_q <= ST_FIN;
               end
`ifdef MATMUL_SCHED_TIMEOUT_EN
               else if (timeout_hit) begin
                  done_q  <= done_d;
                  busy_q  <= 1'b0;
                  rr_q    <= sel_q;
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
               end else begin
                  wdog_q  <= wdog_q + 1'b1;
               end
`endif
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.start_mul = start_mul_q;
   assign bus.sel       = sel_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.jobs      = jobs_q;
`ifdef MATMUL_SCHED_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: doc/matmul_sched.md
Name: matmul_sched

Overview:
- Round-robin scheduler that shares one vector matmul engine among NUM_REQ requesters.
- Each requester owns its own A/B/out memory banks. The scheduler selects a bank set through `sel`, issues the one-cycle start pulse, waits for the engine's one-cycle done pulse, then acknowledges the owner.
- Sits between the host-side request registers and the engine plus bank mux.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- SEL_BITS, $clog2(NUM_REQ), width of the grant index.
- CNT_BITS, 16, width of the completed-job counter.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; only used with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its done bit.
- start_mul  out  1  start pulse to the engine; exactly one cycle.
- mul_done  in  1  engine completion pulse; one cycle.
- sel  out  SEL_BITS  index of the bank set routed to the engine.
- busy  out  1  high from grant until completion.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- err  out  1  sticky watchdog error; tied 0 without the feature.
- jobs  out  CNT_BITS  completed-job count; wraps modulo 2^CNT_BITS.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; start_mul=0, sel=0, busy=0, done=0, err=0, jobs=0.
  - Round-robin pointer rr = NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: if any req bit is set, grant the first set bit searching rr+1, rr+2, … modulo NUM_REQ. Register sel=grant, busy=1, go to SETUP. If no req bit is set, stay in IDLE.
  - SETUP: one cycle so the bank mux settles. Drive start_mul=1 for this cycle only, then go to RUN.
  - RUN: wait for mul_done=1, then go to FIN.
  - FIN: done[sel]=1 for one cycle, jobs+=1, rr=sel, busy=0, go to IDLE.
- Latency:
  - req rising in IDLE → start_mul two cycles later (IDLE→SETUP edge, then SETUP cycle).
  - mul_done → done[sel] one cycle later.
  - Minimum turnaround between back-to-back jobs: 4 cycles plus engine latency.
- sel is stable from the SETUP cycle through the FIN cycle inclusive.
- A requester must keep req high until its done pulse.
- A req deassert during SETUP/RUN/FIN is ignored: the job runs to completion and done is still pulsed.
- The owner's req may still be high in the cycle after done. IDLE re-arbitrates with rr=owner, so the owner is served again only if no other requester is pending (fairness).
- mul_done seen in IDLE or SETUP is spurious: ignore it, no state change.
- mul_done in the same cycle as start_mul (SETUP) is ignored; completion is only accepted in RUN.
- jobs wraps from 2^CNT_BITS-1 to 0 with no flag.
- Reset asserted mid-job aborts immediately to the reset values. No done pulse is emitted; the engine's later mul_done lands in IDLE and is ignored.
- Only one bit of done is ever set; done and start_mul are never high in the same cycle.

Optional Feature:
- Macro: MATMUL_SCHED_TIMEOUT_EN.
- With the macro, a watchdog counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT_CYC without mul_done:
  - set err=1 (sticky until reset);
  - pulse done[sel] as normal via FIN;
  - do not increment jobs.
- Without the macro: no counter, err is tied 0, and RUN waits indefinitely.

Decomposition:
- Shared package holds the state encoding (IDLE, SETUP, RUN, FIN, 2-bit) and a localparam for the default TIMEOUT_CYC.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req and rr; outputs are a grant index and an any-valid flag. It is reusable by other shared-resource arbiters in the design.

Test Plan:
- Single requester: reset, then req=4'b0001.
  - start_mul pulses 2 cycles later with sel=0.
  - Drive mul_done 10 cycles after start → done=4'b0001 the next cycle, jobs=1, busy=0.
- All requesters: req=4'b1111 held, each dropped after its done.
  - Grant order is 0,1,2,3, each with a single start_mul.
  - jobs=4; no overlapping busy periods.
- Fairness: req0 held continuously, req2 high.
  - Order is 0,2,0,2.
  - Requester 0 is never granted twice in a row while req2 is pending.
- Spurious and mid-job events:
  - mul_done pulsed in IDLE → no done, jobs unchanged.
  - rst=0 asserted during RUN → all outputs return to reset values immediately; the later mul_done is ignored.
- Timeout (macro defined), TIMEOUT_CYC=16, no mul_done:
  - err=1 and done[sel] pulse 17-18 cycles after start_mul; jobs unchanged.
  - err stays 1 across later successful jobs.
- Counter wrap: CNT_BITS=2, run 5 jobs → jobs reads 1.
